irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_irq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// ============================================================================
// irq_ctrl -- prioritised interrupt controller with a small bus register file
//
// Collects up to N_IRQ device interrupt lines, latches them per source as
// edge- or level-triggered pending bits, and presents the lowest-index
// enabled pending source to the CPU as an int_req / int_id pair. The CPU
// acknowledges with int_ack, services the source, then writes ACTIVE to
// signal end-of-interrupt (EOI).
//
// Register map (word select addr[3:2]):
//   0 MASK   RW   1 = source enabled
//   1 PEND   R    pending sources; write 1 to clear (edge-mode bits only)
//   2 ACTIVE R    bit 31 = in service, bits 2:0 = id; any write = EOI
//   3 MODE   RW   1 = edge-triggered, 0 = level-sensitive
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   we         bus write strobe
//   addr       register word select
//   DEV_WD     bus write data
//   DEVIrq_RD  combinational read data
//   irq_in     device interrupt lines (bit 0 = timer, highest priority)
//   int_req    interrupt request to CP0
//   int_id     index of the requested source
//   int_ack    one-cycle acknowledge from the CPU
// ============================================================================
module irq_ctrl #(
    parameter int N_IRQ = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [3:2]       addr,
    input  logic [31:0]      DEV_WD,
    output logic [31:0]      DEVIrq_RD,
    input  logic [N_IRQ-1:0] irq_in,
    output logic             int_req,
    output logic [2:0]       int_id,
    input  logic             int_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t            state;
    logic [N_IRQ-1:0]  irq_m, irq_s, irq_d;
    logic [N_IRQ-1:0]  mask, mode, pend;
    logic              active_busy;
    logic [2:0]        active_id;

    logic [N_IRQ-1:0]  edge_set, eligible, id_onehot, w1c, ack_clr;
    logic [2:0]        sel_id;
    logic              any_elig, cur_elig, ack_take, eoi;
    logic              wr_mask, wr_pend, wr_act, wr_mode;

    // Write data above the implemented sources is deliberately discarded.
    logic              unused_wd;
    assign unused_wd = ^DEV_WD[31:N_IRQ];

    // ------------------------------------------------------------------
    // Bus write decode
    // ------------------------------------------------------------------
    assign wr_mask = we && (addr == 2'd0);
    assign wr_pend = we && (addr == 2'd1);
    assign wr_act  = we && (addr == 2'd2);
    assign wr_mode = we && (addr == 2'd3);

    // ------------------------------------------------------------------
    // Selection and per-source control vectors
    // ------------------------------------------------------------------
    assign edge_set = irq_s & ~irq_d;
    assign eligible = pend & mask;
    assign any_elig = |eligible;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_id    = 3'd0;
        id_onehot = '0;
        // Walk from the top down so the lowest eligible index wins.
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel_id = 3'(i);
        end
        for (int i = 0; i < N_IRQ; i++) begin
            id_onehot[i] = (int_id == 3'(i));
        end
    end

    assign cur_elig = |(eligible & id_onehot);
    assign ack_take = (state == REQ) && int_ack;
    assign eoi      = (state == SERV) && wr_act;
    assign w1c      = wr_pend  ? DEV_WD[N_IRQ-1:0] : '0;
    // Acknowledge consumes the pending bit only for edge-mode sources;
    // a level source stays pending while its line is held.
    assign ack_clr  = ack_take ? (id_onehot & mode) : '0;

    // ------------------------------------------------------------------
    // Synchroniser and delayed copy for edge detection
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_m <= '0;
            irq_s <= '0;
            irq_d <= '0;
        end else begin
            irq_m <= irq_in;
            irq_s <= irq_m;
            irq_d <= irq_s;
        end
    end

    // ------------------------------------------------------------------
    // MASK / MODE / PEND registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
            mode <= '0;
            pend <= '0;
        end else begin
            if (wr_mask) mask <= DEV_WD[N_IRQ-1:0];
            if (wr_mode) mode <= DEV_WD[N_IRQ-1:0];
            // Level bits mirror the synchronised line; edge bits are sticky,
            // and a new edge wins over a same-cycle clear.
            pend <= (~mode & irq_s) |
                    ( mode & (edge_set | (pend & ~w1c & ~ack_clr)));
        end
    end

    // ------------------------------------------------------------------
    // Request FSM with registered int_req / int_id and ACTIVE record
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            int_req     <= 1'b0;
            int_id      <= 3'd0;
            active_busy <= 1'b0;
            active_id   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_elig) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                        int_id  <= sel_id;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state       <= SERV;
                        int_req     <= 1'b0;
                        active_busy <= 1'b1;
                        active_id   <= int_id;
                    end else if (!cur_elig) begin
                        // Latched source withdrawn: give up; a higher
                        // priority newcomer is picked up from IDLE.
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                SERV: begin
                    if (eoi) begin
                        state       <= IDLE;
                        active_busy <= 1'b0;
                        active_id   <= 3'd0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux (unimplemented bits read as zero)
    // ------------------------------------------------------------------
    always_comb begin
        DEVIrq_RD = 32'd0;
        case (addr)
            2'd0: DEVIrq_RD[N_IRQ-1:0] = mask;
            2'd1: DEVIrq_RD[N_IRQ-1:0] = pend;
            2'd2: begin
                DEVIrq_RD[31]  = active_busy;
                DEVIrq_RD[2:0] = active_id;
            end
            default: DEVIrq_RD[N_IRQ-1:0] = mode;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// tb_irq_ctrl -- directed self-checking bench for irq_ctrl (N_IRQ = 6)
//
// Inputs are changed 1 ns after a rising edge and outputs are sampled there,
// so every "step" is one clock edge followed by a settle delay.
// ============================================================================
module tb_irq_ctrl;

    localparam int N_IRQ = 6;

    logic             clk;
    logic             rst_n;
    logic             we;
    logic [3:2]       addr;
    logic [31:0]      DEV_WD;
    logic [31:0]      DEVIrq_RD;
    logic [N_IRQ-1:0] irq_in;
    logic             int_req;
    logic [2:0]       int_id;
    logic             int_ack;

    int n_checks = 0;
    int n_errors = 0;

    irq_ctrl #(.N_IRQ(N_IRQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .addr      (addr),
        .DEV_WD    (DEV_WD),
        .DEVIrq_RD (DEVIrq_RD),
        .irq_in    (irq_in),
        .int_req   (int_req),
        .int_id    (int_id),
        .int_ack   (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is a few hundred cycles at most.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        we     = 1'b1;
        addr   = a;
        DEV_WD = d;
        step();
        we     = 1'b0;
        DEV_WD = 32'd0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a,
                            input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, DEVIrq_RD, exp);
    endtask

    task automatic req_check(input string tag, input logic exp_req,
                             input logic [2:0] exp_id);
        check({tag, "_req"}, {31'd0, int_req}, {31'd0, exp_req});
        check({tag, "_id"},  {29'd0, int_id},  {29'd0, exp_id});
    endtask

    task automatic ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        we      = 1'b0;
        addr    = 2'd0;
        DEV_WD  = 32'd0;
        irq_in  = '0;
        int_ack = 1'b0;

        // ---------------- reset state ----------------
        #2;
        req_check("rst", 1'b0, 3'd0);
        rd_check("rst_mask", 2'd0, 32'h0);
        rd_check("rst_pend", 2'd1, 32'h0);
        rd_check("rst_act",  2'd2, 32'h0);
        rd_check("rst_mode", 2'd3, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // ---------------- single edge source, 4-cycle latency ----------------
        bus_write(2'd0, 32'hFFFF_FF01);       // upper bits ignored
        bus_write(2'd3, 32'h0000_0001);
        rd_check("mask_rb", 2'd0, 32'h01);
        rd_check("mode_rb", 2'd3, 32'h01);
        irq_in = 6'b000001;
        step();                               // edge 1
        irq_in = '0;
        check("lat_e1", {31'd0, int_req}, 32'd0);
        step();                               // edge 2
        check("lat_e2", {31'd0, int_req}, 32'd0);
        step();                               // edge 3: PEND set
        check("lat_e3", {31'd0, int_req}, 32'd0);
        step();                               // edge 4: request
        req_check("lat_e4", 1'b1, 3'd0);
        rd_check("pend_01", 2'd1, 32'h01);

        // ---------------- ack, service, EOI ----------------
        ack();
        check("ack_req", {31'd0, int_req}, 32'd0);
        rd_check("ack_pend", 2'd1, 32'h00);
        rd_check("ack_act",  2'd2, 32'h8000_0000);
        step(3);
        check("serv_req", {31'd0, int_req}, 32'd0);
        bus_write(2'd2, 32'h0);               // EOI
        rd_check("eoi_act", 2'd2, 32'h0);
        ack();                                // ack in IDLE must be ignored
        rd_check("idle_ack_act", 2'd2, 32'h0);
        check("idle_ack_req", {31'd0, int_req}, 32'd0);

        // ---------------- priority: bits 3 and 1 together ----------------
        bus_write(2'd0, 32'h3F);
        bus_write(2'd3, 32'h3F);
        irq_in = 6'b001010;
        step(4);
        req_check("prio1", 1'b1, 3'd1);
        rd_check("prio_pend", 2'd1, 32'h0A);
        ack();
        rd_check("prio_ack_pend", 2'd1, 32'h08);
        rd_check("prio_ack_act",  2'd2, 32'h8000_0001);
        bus_write(2'd2, 32'h0);               // EOI -> IDLE
        check("prio_eoi_req", {31'd0, int_req}, 32'd0);
        step();
        req_check("prio3", 1'b1, 3'd3);
        ack();
        rd_check("prio3_act", 2'd2, 32'h8000_0003);
        bus_write(2'd2, 32'h0);
        rd_check("prio_done_pend", 2'd1, 32'h00);

        // ---------------- set and W1C in the same cycle ----------------
        bus_write(2'd0, 32'h0);
        irq_in = 6'b011010;                   // new edge on bit 4 only
        step(2);
        bus_write(2'd1, 32'h10);              // lands on the set cycle
        rd_check("set_w1c", 2'd1, 32'h10);
        bus_write(2'd1, 32'h10);
        rd_check("w1c_only", 2'd1, 32'h00);
        irq_in = '0;
        step(3);

        // ---------------- level mode ----------------
        bus_write(2'd3, 32'h0);
        bus_write(2'd0, 32'h04);
        irq_in = 6'b000100;
        step(3);
        check("lvl_e3", {31'd0, int_req}, 32'd0);
        step();
        req_check("lvl_req", 1'b1, 3'd2);
        step(3);
        check("lvl_hold", {31'd0, int_req}, 32'd1);
        bus_write(2'd1, 32'h04);
        rd_check("lvl_w1c", 2'd1, 32'h04);
        irq_in = '0;
        step(4);
        check("lvl_drop", {31'd0, int_req}, 32'd0);
        rd_check("lvl_drop_pend", 2'd1, 32'h00);

        // ---------------- mask withdrawn while requesting ----------------
        irq_in = 6'b000100;
        step(4);
        req_check("mreq", 1'b1, 3'd2);
        bus_write(2'd0, 32'h0);
        step();
        check("mask_off_req", {31'd0, int_req}, 32'd0);
        rd_check("mask_off_pend", 2'd1, 32'h04);
        bus_write(2'd0, 32'h04);
        step();
        req_check("mask_on", 1'b1, 3'd2);

        // Higher-priority source arriving during REQ keeps int_id.
        bus_write(2'd0, 32'h05);
        irq_in = 6'b000101;
        step(5);
        req_check("no_preempt", 1'b1, 3'd2);
        ack();
        rd_check("lvl_ack_act",  2'd2, 32'h8000_0002);
        rd_check("lvl_ack_pend", 2'd1, 32'h05);
        step();
        bus_write(2'd1, 32'h0);               // not EOI: still in service
        check("serv_hold_req", {31'd0, int_req}, 32'd0);

        // ---------------- asynchronous reset during SERV ----------------
        rst_n = 1'b0;
        #1;
        req_check("arst", 1'b0, 3'd0);
        rd_check("arst_mask", 2'd0, 32'h0);
        rd_check("arst_pend", 2'd1, 32'h0);
        rd_check("arst_act",  2'd2, 32'h0);
        rd_check("arst_mode", 2'd3, 32'h0);
        step(2);
        rst_n = 1'b1;
        step(5);                              // lines still high, mask now 0
        check("post_rst_req", {31'd0, int_req}, 32'd0);
        rd_check("post_rst_pend", 2'd1, 32'h05);
        irq_in = '0;
        step(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
